split_head_streamer: RTL and testbench

//  Downstream of the Q/K/V split stage. Captures one split tensor [S][H][D] from a flat bus and re-emits it

---
 rtl/autotrans_pkg.sv | 19 +
 rtl/split_beat_counter.sv | 62 ++++++
 rtl/split_head_streamer.sv | 109 ++++++++++
 tb/tb_split_head_streamer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/autotrans_pkg.sv
// Shared constants, FSM state type and flat-bus addressing for the attention transpose streamers.
package autotrans_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefSeqLen    = 128;
  localparam int unsigned DefHeadNum   = 12;
  localparam int unsigned DefHeadDim   = 64;

  typedef enum logic {StIdle, StStream} stream_state_e;

  // Bit offset of element (s,h,d) on a flat [S][H][D] bus.
  function automatic int unsigned elem_offset(input int unsigned s, input int unsigned h,
                                              input int unsigned d, input int unsigned head_num,
                                              input int unsigned head_dim,
                                              input int unsigned data_width);
    return data_width * ((s * head_num + h) * head_dim + d);
  endfunction

endpackage

// File: rtl/split_beat_counter.sv
// Nested row/head position counter: seq is the inner index, head the outer one.
module split_beat_counter
  import autotrans_pkg::*;
#(
  parameter int unsigned SEQ_LEN  = DefSeqLen,
  parameter int unsigned HEAD_NUM = DefHeadNum,
  localparam int unsigned SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int unsigned HW = (HEAD_NUM > 1) ? $clog2(HEAD_NUM) : 1
) (
  input  logic          clk_p,
  input  logic          rst_p,
  input  logic          clear,
  input  logic          advance,
  output logic [SW-1:0] seq,
  output logic [HW-1:0] head,
  output logic [SW-1:0] seq_next,
  output logic [HW-1:0] head_next,
  output logic          head_last,
  output logic          last
);

  logic [SW-1:0] seq_q, seq_d;
  logic [HW-1:0] head_q, head_d;

  always_comb begin
    head_last = (seq_q == SW'(SEQ_LEN - 1));
    last      = head_last && (head_q == HW'(HEAD_NUM - 1));

    // Position after the current one; wraps to (0,0) past the final beat.
    if (head_last) begin
      seq_next  = '0;
      head_next = last ? '0 : head_q + 1'b1;
    end else begin
      seq_next  = seq_q + 1'b1;
      head_next = head_q;
    end

    seq_d  = seq_q;
    head_d = head_q;
    if (clear) begin
      seq_d  = '0;
      head_d = '0;
    end else if (advance) begin
      seq_d  = seq_next;
      head_d = head_next;
    end
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      seq_q  <= '0;
      head_q <= '0;
    end else begin
      seq_q  <= seq_d;
      head_q <= head_d;
    end
  end

  assign seq  = seq_q;
  assign head = head_q;

endmodule

// File: rtl/split_head_streamer.sv
// Captures one [S][H][D] tensor into a frame buffer and replays it head-major, one row per beat.
module split_head_streamer
  import autotrans_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned SEQ_LEN    = DefSeqLen,
  parameter int unsigned HEAD_NUM   = DefHeadNum,
  parameter int unsigned HEAD_DIM   = DefHeadDim,
  localparam int unsigned ROW_W   = DATA_WIDTH * HEAD_DIM,
  localparam int unsigned FRAME_W = ROW_W * HEAD_NUM * SEQ_LEN,
  localparam int unsigned SW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int unsigned HW      = (HEAD_NUM > 1) ? $clog2(HEAD_NUM) : 1
) (
  input  logic               clk_p,
  input  logic               rst_p,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] split_matrix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic [HW-1:0]      out_head,
  output logic [SW-1:0]      out_seq,
  output logic               out_head_last,
  output logic               out_last
);

  stream_state_e state_q, state_d;
  logic [FRAME_W-1:0] frame_q;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   next_row;
  logic               capture, advance;

  logic [SW-1:0] cnt_seq, nxt_seq;
  logic [HW-1:0] cnt_head, nxt_head;
  logic          cnt_head_last, cnt_last;
  int unsigned   next_base;

  split_beat_counter #(
    .SEQ_LEN (SEQ_LEN),
    .HEAD_NUM(HEAD_NUM)
  ) u_counter (
    .clk_p    (clk_p),
    .rst_p    (rst_p),
    .clear    (capture),
    .advance  (advance),
    .seq      (cnt_seq),
    .head     (cnt_head),
    .seq_next (nxt_seq),
    .head_next(nxt_head),
    .head_last(cnt_head_last),
    .last     (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          advance = 1'b1;
          if (cnt_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Row for the position the counter moves to on this handshake.
  always_comb begin
    next_base = elem_offset(32'(nxt_seq), 32'(nxt_head), 0, HEAD_NUM, HEAD_DIM, DATA_WIDTH);
    next_row  = frame_q[next_base +: ROW_W];
  end

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q <= StIdle;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        row_q <= split_matrix[ROW_W-1:0];
      end else if (advance && !cnt_last) begin
        row_q <= next_row;
      end
    end
  end

  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk_p) begin
    if (capture) frame_q <= split_matrix;
  end

  assign in_ready      = (state_q == StIdle);
  assign out_valid     = (state_q == StStream);
  assign out_row       = row_q;
  assign out_head      = cnt_head;
  assign out_seq       = cnt_seq;
  assign out_head_last = out_valid && cnt_head_last;
  assign out_last      = out_valid && cnt_last;

endmodule

// File: tb/tb_split_head_streamer.sv
// Directed and randomised checks of split_head_streamer with S=2, H=3, D=4 against a beat scoreboard.
module tb_split_head_streamer;

  localparam int unsigned DW      = 8;
  localparam int unsigned S       = 2;
  localparam int unsigned H       = 3;
  localparam int unsigned D       = 4;
  localparam int unsigned ROW_W   = DW * D;
  localparam int unsigned FRAME_W = ROW_W * H * S;

  typedef struct packed {
    logic [31:0] row;
    logic [1:0]  h;
    logic        s;
    logic        hl;
    logic        last;
  } beat_t;

  logic               clk_p = 1'b0;
  logic               rst_p;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] split_matrix;
  logic               out_valid;
  logic               out_ready;
  logic [ROW_W-1:0]   out_row;
  logic [1:0]         out_head;
  logic [0:0]         out_seq;
  logic               out_head_last;
  logic               out_last;

  always #5 clk_p = ~clk_p;

  split_head_streamer #(
    .DATA_WIDTH(DW),
    .SEQ_LEN   (S),
    .HEAD_NUM  (H),
    .HEAD_DIM  (D)
  ) dut (
    .clk_p        (clk_p),
    .rst_p        (rst_p),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .split_matrix (split_matrix),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_head     (out_head),
    .out_seq      (out_seq),
    .out_head_last(out_head_last),
    .out_last     (out_last)
  );

  int    checks = 0;
  int    errors = 0;
  int    beats  = 0;
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FRAME_W-1:0] make_frame(input int base);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int s = 0; s < S; s++)
      for (int h = 0; h < H; h++)
        for (int d = 0; d < D; d++)
          f[DW*((s*H+h)*D+d) +: DW] = 8'(base + s*16 + h*4 + d);
    return f;
  endfunction

  // Reference permute: beats ordered head-major, each row taken from (s,h) of the flat bus.
  task automatic push_frame(input logic [FRAME_W-1:0] f);
    beat_t b;
    for (int h = 0; h < H; h++)
      for (int s = 0; s < S; s++) begin
        b.row  = f[ROW_W*(s*H+h) +: ROW_W];
        b.h    = 2'(h);
        b.s    = 1'(s);
        b.hl   = (s == S-1);
        b.last = (s == S-1) && (h == H-1);
        exp_q.push_back(b);
      end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic send(input logic [FRAME_W-1:0] f);
    chk("send_in_ready", 64'(in_ready), 64'd1);
    in_valid     = 1'b1;
    split_matrix = f;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_left(input int left, input int budget);
    int n = 0;
    while (exp_q.size() > left && n < budget) begin
      tick();
      n++;
    end
    chk("wait_timeout", 64'(exp_q.size()), 64'(left));
  endtask

  always @(negedge clk_p) begin
    beat_t e;
    if (!rst_p && out_valid && out_ready) begin
      beats++;
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("row", 64'(out_row), 64'(e.row));
        chk("head", 64'(out_head), 64'(e.h));
        chk("seq", 64'(out_seq), 64'(e.s));
        chk("head_last", 64'(out_head_last), 64'(e.hl));
        chk("last", 64'(out_last), 64'(e.last));
      end
    end
  end

  initial begin
    logic [FRAME_W-1:0] f0, f1, fr;
    int b0;

    // Reset
    rst_p        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    split_matrix = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_head_last", 64'(out_head_last), 64'd0);
    rst_p = 1'b0;
    tick();

    // Single frame, consumer always ready
    f0 = make_frame(0);
    f1 = make_frame(32'h40);
    out_ready = 1'b1;
    b0 = beats;
    push_frame(f0);
    send(f0);
    chk("t2_first_row", 64'(out_row), 64'h03020100);
    drain(50, 1'b0);
    chk("t2_in_ready_after", 64'(in_ready), 64'd1);
    chk("t2_valid_after", 64'(out_valid), 64'd0);
    chk("t2_beats", 64'(beats - b0), 64'd6);

    // Backpressure after the first beat
    out_ready = 1'b0;
    b0 = beats;
    push_frame(f0);
    send(f0);
    chk("t3_first_row", 64'(out_row), 64'h03020100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_row", 64'(out_row), 64'h13121110);
      chk("t3_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    drain(50, 1'b0);
    chk("t3_beats", 64'(beats - b0), 64'd6);

    // Second frame offered throughout streaming of the first
    push_frame(f0);
    push_frame(f1);
    in_valid     = 1'b1;
    split_matrix = f0;
    tick();
    split_matrix = f1;
    wait_left(6, 50);
    chk("t4_idle_in_ready", 64'(in_ready), 64'd1);
    chk("t4_idle_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("t4_second_first_row", 64'(out_row), 64'h43424140);
    drain(50, 1'b0);

    // Reset in the middle of a frame
    push_frame(f0);
    send(f0);
    wait_left(3, 50);
    rst_p     = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_last", 64'(out_last), 64'd0);
    rst_p = 1'b0;
    exp_q.delete();
    tick();
    out_ready = 1'b1;
    push_frame(f0);
    send(f0);
    chk("t5_restart_head", 64'(out_head), 64'd0);
    chk("t5_restart_seq", 64'(out_seq), 64'd0);
    chk("t5_restart_row", 64'(out_row), 64'h03020100);
    drain(50, 1'b0);

    // Random frames with random consumer stalls
    b0 = beats;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < int'(H * S); i++) fr[i*32 +: 32] = $urandom;
      push_frame(fr);
      out_ready = 1'($urandom_range(0, 1));
      send(fr);
      drain(2000, 1'b1);
    end
    chk("t6_beats", 64'(beats - b0), 64'd120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
